// File: rtl/channel_loader.sv
// channel_loader
//   Collects eight real-valued channel rows (plus their received samples)
//   into a full 8x8 matrix frame, accumulating per-column energy as the rows
//   arrive. Once row 7 is taken the frame is held on the outputs until the
//   downstream decomposition stage accepts it.
//
//   Widths come from parameters.v (`WL element width, `COLNORM_WL norm width);
//   the guarded defaults below apply when that file is not in the build.
//   Optional macro CHANNEL_LOADER_SAT_EN: saturate shifted column norms that do
//   not fit in `COLNORM_WL bits (default build truncates to the low bits).
//
//   Ports
//     clk         sole clock, rising edge
//     rst         asynchronous active-high reset
//     Hrow_i      one channel row, element c at [`WL*c +: `WL], signed
//     y_i         received sample for that row, signed
//     in_valid    Hrow_i/y_i valid
//     in_ready    loader can accept a row
//     Hmatrix_o   assembled matrix, element (r,c) at [`WL*8*r + `WL*c +: `WL]
//     Yarray_o    assembled samples, element r at [`WL*r +: `WL]
//     colnorm_o   unsigned column norm c at [`COLNORM_WL*c +: `COLNORM_WL]
//     colorder_o  column index for slot c at [3*c +: 3] (identity)
//     out_valid   complete frame present on the outputs
//     out_ready   downstream accepts the frame

`ifndef WL
`define WL 16
`endif
`ifndef COLNORM_WL
`define COLNORM_WL 7
`endif

module channel_loader #(
    parameter int NORM_SHIFT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [8*`WL-1:0]          Hrow_i,
    input  logic [`WL-1:0]            y_i,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [8*8*`WL-1:0]        Hmatrix_o,
    output logic [8*`WL-1:0]          Yarray_o,
    output logic [8*`COLNORM_WL-1:0]  colnorm_o,
    output logic [8*3-1:0]            colorder_o,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int unsigned W     = `WL;
    localparam int unsigned CNW   = `COLNORM_WL;
    localparam int unsigned ACC_W = 2*W + 3;

    typedef enum logic {LOAD, HOLD} state_t;

    state_t            state, state_next;
    logic [2:0]        rowcnt;
    logic [ACC_W-1:0]  acc [8];
    logic [2*W-1:0]    sq  [8];
    logic              row_take;
    logic              frame_take;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        row_take   = 1'b0;
        frame_take = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    row_take = 1'b1;
                    if (rowcnt == 3'd7) state_next = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    frame_take = 1'b1;
                    state_next = LOAD;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    // Squaring the sign-extended element modulo 2^(2W) yields the exact square,
    // since |x|^2 <= 2^(2W-2) always fits; this covers the most negative input.
    always_comb begin
        for (int unsigned c = 0; c < 8; c++) begin
            logic [2*W-1:0] ext;
            ext   = {{W{Hrow_i[W*c + W - 1]}}, Hrow_i[W*c +: W]};
            sq[c] = ext * ext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rowcnt    <= '0;
            Hmatrix_o <= '0;
            Yarray_o  <= '0;
            for (int unsigned c = 0; c < 8; c++) acc[c] <= '0;
        end else if (row_take) begin
            Hmatrix_o[W*8*rowcnt +: 8*W] <= Hrow_i;
            Yarray_o[W*rowcnt +: W]      <= y_i;
            rowcnt                       <= rowcnt + 3'd1;
            for (int unsigned c = 0; c < 8; c++) acc[c] <= acc[c] + {3'b000, sq[c]};
        end else if (frame_take) begin
            // Matrix and samples are left in place; the next frame overwrites them.
            for (int unsigned c = 0; c < 8; c++) acc[c] <= '0;
        end
    end

    // Norms follow acc directly: zero after reset/accept, frozen while holding.
    always_comb begin
        logic [ACC_W-1:0] shifted;
        colnorm_o = '0;
        shifted   = '0;
        for (int unsigned c = 0; c < 8; c++) begin
            shifted = acc[c] >> NORM_SHIFT;
`ifdef CHANNEL_LOADER_SAT_EN
            colnorm_o[CNW*c +: CNW] = (|shifted[ACC_W-1:CNW]) ? '1 : shifted[CNW-1:0];
`else
            colnorm_o[CNW*c +: CNW] = shifted[CNW-1:0];
`endif
        end
    end

    always_comb begin
        colorder_o = '0;
        for (int unsigned c = 0; c < 8; c++) colorder_o[3*c +: 3] = 3'(c);
    end

endmodule

// File: tb/tb_channel_loader.sv
`ifndef WL
`define WL 16
`endif
`ifndef COLNORM_WL
`define COLNORM_WL 7
`endif

module tb_channel_loader;

    localparam int W   = `WL;
    localparam int CNW = `COLNORM_WL;
    localparam int NS  = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [8*W-1:0]       Hrow_i;
    logic [W-1:0]         y_i;
    logic                 in_valid;
    logic                 in_ready;
    logic [8*8*W-1:0]     Hmatrix_o;
    logic [8*W-1:0]       Yarray_o;
    logic [8*CNW-1:0]     colnorm_o;
    logic [23:0]          colorder_o;
    logic                 out_valid;
    logic                 out_ready;

    channel_loader #(.NORM_SHIFT(NS)) dut (
        .clk        (clk),
        .rst        (rst),
        .Hrow_i     (Hrow_i),
        .y_i        (y_i),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .Hmatrix_o  (Hmatrix_o),
        .Yarray_o   (Yarray_o),
        .colnorm_o  (colnorm_o),
        .colorder_o (colorder_o),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    // Reference frame: plain integers, one entry per matrix element / sample.
    int h  [8][8];
    int yv [8];
    int errors = 0;
    int checks = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] row_bits(input int r);
        logic [127:0] v = '0;
        for (int c = 0; c < 8; c++) v[W*c +: W] = W'(h[r][c]);
        return v;
    endfunction

    function automatic logic [127:0] y_bits();
        logic [127:0] v = '0;
        for (int r = 0; r < 8; r++) v[W*r +: W] = W'(yv[r]);
        return v;
    endfunction

    // Column energy = sum of squares, scaled down, then fitted into CNW bits.
    function automatic logic [127:0] norm_bits();
        logic [127:0] v = '0;
        for (int c = 0; c < 8; c++) begin
            longint e = 0;
            for (int r = 0; r < 8; r++) e += longint'(h[r][c]) * longint'(h[r][c]);
            e = e / (64'sd1 << NS);
`ifdef CHANNEL_LOADER_SAT_EN
            if (e >= (64'sd1 << CNW)) e = (64'sd1 << CNW) - 1;
`else
            e = e % (64'sd1 << CNW);
`endif
            v[CNW*c +: CNW] = CNW'(e);
        end
        return v;
    endfunction

    function automatic logic [127:0] order_bits();
        logic [127:0] v = '0;
        for (int c = 0; c < 8; c++) v[3*c +: 3] = 3'(c);
        return v;
    endfunction

    task automatic fill_const(input int val);
        for (int r = 0; r < 8; r++) begin
            yv[r] = r;
            for (int c = 0; c < 8; c++) h[r][c] = val;
        end
    endtask

    task automatic fill_rand();
        for (int r = 0; r < 8; r++) begin
            yv[r] = int'($urandom_range(0, 65535));
            for (int c = 0; c < 8; c++)
                h[r][c] = ($urandom_range(0, 7) == 0) ? -32768 : int'($urandom_range(0, 65535)) - 32768;
        end
    endtask

    task automatic check_frame(input string tag);
        for (int r = 0; r < 8; r++)
            chk($sformatf("%s_H%0d", tag, r), Hmatrix_o[128*r +: 128], row_bits(r));
        chk({tag, "_Y"},     Yarray_o,   y_bits());
        chk({tag, "_norm"},  colnorm_o,  norm_bits());
        chk({tag, "_order"}, colorder_o, order_bits());
        chk({tag, "_ov"},    out_valid,  1'b1);
        chk({tag, "_ir"},    in_ready,   1'b0);
    endtask

    // Loads rows 0..n-1 of the reference frame, optionally with idle gaps
    // carrying junk data that must be ignored.
    task automatic load_rows(input int n, input bit gaps);
        for (int r = 0; r < n; r++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                Hrow_i   = {$urandom(), $urandom(), $urandom(), $urandom()};
                y_i      = W'($urandom());
                tick();
            end
            chk($sformatf("load_ir_r%0d", r), in_ready, 1'b1);
            chk($sformatf("load_ov_r%0d", r), out_valid, 1'b0);
            in_valid = 1'b1;
            Hrow_i   = row_bits(r);
            y_i      = W'(yv[r]);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("accept_ov", out_valid, 1'b0);
        chk("accept_ir", in_ready,  1'b1);
        chk("accept_norm_clr", colnorm_o, '0);
    endtask

    task automatic stall(input int n);
        out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = ~in_valid;
            Hrow_i   = {$urandom(), $urandom(), $urandom(), $urandom()};
            y_i      = W'($urandom());
            tick();
            check_frame($sformatf("stall%0d", i));
        end
        in_valid = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ov"},    out_valid, 1'b0);
        chk({tag, "_ir"},    in_ready,  1'b1);
        for (int r = 0; r < 8; r++)
            chk($sformatf("%s_H%0d", tag, r), Hmatrix_o[128*r +: 128], '0);
        chk({tag, "_Y"},     Yarray_o,   '0);
        chk({tag, "_norm"},  colnorm_o,  '0);
        chk({tag, "_order"}, colorder_o, order_bits());
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; Hrow_i = '0; y_i = '0;
        #1;
        check_reset_state("por");
        @(negedge clk) rst = 1'b0;
        tick();

        // +4 everywhere, out_ready already high: 8 load cycles + 1 hold cycle.
        fill_const(4);
        out_ready = 1'b1;
        load_rows(8, 1'b0);
        check_frame("pos4");
        tick();
        out_ready = 1'b0;
        chk("pos4_back_ir", in_ready, 1'b1);
        chk("pos4_back_ov", out_valid, 1'b0);

        // -4 gives the same norms; frame held for a while before accept.
        fill_const(-4);
        load_rows(8, 1'b1);
        check_frame("neg4");
        stall(5);
        accept();
        for (int r = 0; r < 8; r++)
            chk($sformatf("kept_H%0d", r), Hmatrix_o[128*r +: 128], row_bits(r));
        chk("kept_Y", Yarray_o, y_bits());

        fill_const(100);
        load_rows(8, 1'b1);
        check_frame("c100");
        accept();

        // Random frames, stalled, then a fresh frame to expose stale energy.
        for (int f = 0; f < 4; f++) begin
            fill_rand();
            load_rows(8, 1'b1);
            check_frame($sformatf("rnd%0d", f));
            if (f[0]) stall(3);
            accept();
        end

        // Reset after 3 accepted rows.
        fill_rand();
        load_rows(3, 1'b1);
        #2 rst = 1'b1;
        #1 check_reset_state("rst_mid");
        #1 rst = 1'b0;
        tick();
        fill_rand();
        load_rows(8, 1'b1);
        check_frame("after_rst");
        accept();

        fill_const(-32768);
        load_rows(8, 1'b1);
        check_frame("min");

        // Reset while holding drops the pending frame.
        #2 rst = 1'b1;
        #1 check_reset_state("rst_hold");
        #1 rst = 1'b0;
        tick();
        fill_rand();
        load_rows(8, 1'b0);
        check_frame("final");
        accept();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
